// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result bundle for serial_adder; SUB exists only with SERIAL_ADDER_SUB_EN
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
`ifdef SERIAL_ADDER_SUB_EN
    logic             SUB;
`endif
    logic [WIDTH-1:0] S;
    logic             C;
    logic             busy;
    logic             done;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, A, B, SUB, input S, C, busy, done);
    modport slave  (input start, A, B, SUB, output S, C, busy, done);
`else
    modport master (output start, A, B, input S, C, busy, done);
    modport slave  (input start, A, B, output S, C, busy, done);
`endif
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first unsigned adder; SERIAL_ADDER_SUB_EN adds A-B mode
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, s_q;
    logic             cy, c_q;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             sub_sel;
    logic             h1_sum, h1_cy, sum_bit, h2_cy, cy_nxt;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_sel = bus.SUB;
`else
    assign sub_sel = 1'b0;
`endif

    // Two half adders chained into the full adder that is reused every cycle.
    assign h1_sum  = a_sr[0] ^ b_sr[0];
    assign h1_cy   = a_sr[0] & b_sr[0];
    assign sum_bit = h1_sum ^ cy;
    assign h2_cy   = h1_sum & cy;
    assign cy_nxt  = h1_cy | h2_cy;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            s_q  <= '0;
            cy   <= 1'b0;
            c_q  <= 1'b0;
            cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr <= bus.A;
                        // Subtraction is A + ~B + 1: invert B and preload the carry.
                        b_sr <= sub_sel ? ~bus.B : bus.B;
                        cy   <= sub_sel;
                        cnt  <= '0;
                        s_q  <= '0;
                        c_q  <= 1'b0;
                    end
                end
                RUN: begin
                    s_q  <= {sum_bit, s_q[WIDTH-1:1]};
                    a_sr <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                    cy   <= cy_nxt;
                    cnt  <= cnt + CW'(1);
                    if (last_bit) begin
                        c_q <= cy_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.S = s_q;
    assign bus.C = c_q;
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial unsigned adder for the adder track.
- Consumes two WIDTH-bit operands, adds them LSB-first over WIDTH clock cycles, and presents the sum and carry-out.
- Contains a single 1-bit add cell (half-adder pair forming a full adder) and a registered carry.
- Sits directly downstream of the combinational half_adder cell. It is the sequential stage that reuses that cell across cycles, trading area for latency.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- A  input  WIDTH  operand A; captured on the accepted start edge
- B  input  WIDTH  operand B; captured on the accepted start edge
- S  output  WIDTH  sum result; valid from done onward, held until the next accepted start
- C  output  1  carry-out of the MSB; same validity as S
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when S/C become valid

Behaviour:
- Reset is asynchronous and active-high: one clock; the rst port is asynchronous active-high.
- rst=1 forces immediately, regardless of clk:
  - state=IDLE
  - S=0, C=0, busy=0, done=0
  - internal operand shift registers=0, carry register=0, bit counter=0
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge loads A and B into the shift registers.
  - Clears carry and counter; clears S and C to 0; moves to RUN.
  - start=0 stays in IDLE with S/C held.
- RUN (busy=1):
  - Each rising edge computes sum = a0^b0^cy and cy' = (a0&b0)|(cy&(a0^b0)), where a0/b0 are the current LSBs.
  - Shifts the sum bit into S from the MSB end (S <= {sum, S[WIDTH-1:1]}).
  - Shifts both operand registers right by one; increments the counter.
  - On the edge that processes bit WIDTH-1: C <= cy', state moves to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then unconditional return to IDLE.
- Latency: if start is accepted at edge E0, bits are processed at edges E1..E_WIDTH. done is high in the cycle following E_WIDTH, so done rises WIDTH cycles after the accepting edge.
- Throughput: one operation per WIDTH+2 cycles.
- The combined result {C,S} equals (A+B) mod 2^(WIDTH+1), i.e. exact unsigned addition.
- start while busy=1 or done=1 is ignored; no queuing; operands under computation are unaffected.
- A/B changing after the accepting edge has no effect on the result.
- rst asserted mid-RUN aborts the operation; the partial S is discarded to 0. After release, the block waits in IDLE for a fresh start.
- Back-to-back: start held high continuously produces one operation per WIDTH+2 cycles (accepted on each IDLE cycle).

Optional Feature:
- Macro SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port SUB (1 bit), captured with A/B on the accepted start edge.
  - SUB=1 computes A-B as A + ~B + 1: the B register loads ~B and the carry register initialises to 1.
  - C=1 means no borrow (A>=B); C=0 means borrow.
  - SUB=0 behaves exactly as the base block.
- Undefined: no SUB port; addition only; carry always initialises to 0.

Test Plan:
- Reset, then start with A=0x00, B=0x00 (WIDTH=8) -> busy high for 8 cycles, then done pulse for 1 cycle with S=0x00, C=0; S/C hold afterwards.
- A=0xFF, B=0x01 -> S=0x00, C=1. Then A=0x5A, B=0x3C -> S=0x96, C=0; done exactly 8 cycles after each accepting edge.
- Start with A=0x12, B=0x34; re-pulse start with A=0xFF, B=0xFF on cycle 3 of RUN -> second request ignored; result S=0x46, C=0; no extra done pulse.
- Start with A=0xAA, B=0x55; assert rst asynchronously (between clock edges) at cycle 4 -> S=0, C=0, busy=0, done=0 immediately. After release and a new start with A=0x01, B=0x02 -> S=0x03, C=0.
- start held high for 30 cycles with A=0x80, B=0x80 -> done pulses every 10 cycles; each gives S=0x00, C=1.
- SERIAL_ADDER_SUB_EN defined: SUB=1, A=0x10, B=0x01 -> S=0x0F, C=1. Then SUB=1, A=0x01, B=0x02 -> S=0xFF, C=0.
